// File: rtl/peripheral_bridge_apb4_pkg.sv
// Shared types and constants for the APB4-to-Wishbone RAM bridge.
package peripheral_bridge_apb4_pkg;

  // Bridge transfer states
  typedef enum logic [1:0] {
    IDLE,
    BUS,
    RESP
  } state_t;

  // Wishbone cycle-type and burst-type identifiers
  localparam logic [2:0] CLASSIC      = 3'b000;
  localparam logic [2:0] END_OF_BURST = 3'b111;
  localparam logic [1:0] LINEAR       = 2'b00;

  // True when addr falls inside the 2^aw byte window starting at zero
  function automatic logic ADDR_OK(input logic [63:0] addr, input int unsigned aw);
    return (addr >> aw) == 64'd0;
  endfunction

endpackage

// File: rtl/peripheral_bridge_apb4_timeout.sv
// BUS-phase watchdog: counts cycles while enabled and flags the last allowed one.
module peripheral_bridge_apb4_timeout #(
  parameter int unsigned LIMIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = (LIMIT < 2) ? 1 : $clog2(LIMIT);
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] count_q;

  // Cycle counter; saturates at the limit so it can never wrap back to zero
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en && (count_q != LAST)) begin
      count_q <= count_q + 1'b1;
    end
  end

  // Count holds the number of earlier BUS cycles, so LAST marks the LIMIT-th one
  assign expired = en & (count_q == LAST);

endmodule

// File: rtl/peripheral_bridge_apb4.sv
// APB4 slave front-end issuing one classic Wishbone cycle per APB transfer
// toward the single-port RAM. Out-of-range addresses are answered locally
// with an error. Define PERIPHERAL_BRIDGE_APB4_TIMEOUT_EN to abort BUS
// cycles that see neither ack nor err within TIMEOUT cycles.
module peripheral_bridge_apb4
  import peripheral_bridge_apb4_pkg::*;
#(
  parameter int unsigned PAW     = 32,
  parameter int unsigned AW      = 8,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              apb4_clk_i,
  input  logic              apb4_rst_i,
  input  logic [PAW-1:0]    apb4_paddr_i,
  input  logic              apb4_psel_i,
  input  logic              apb4_penable_i,
  input  logic              apb4_pwrite_i,
  input  logic [DW-1:0]     apb4_pwdata_i,
  input  logic [DW/8-1:0]   apb4_pstrb_i,
  output logic              apb4_pready_o,
  output logic [DW-1:0]     apb4_prdata_o,
  output logic              apb4_pslverr_o,
  output logic [AW-1:0]     wb_adr_o,
  output logic [DW-1:0]     wb_dat_o,
  output logic [DW/8-1:0]   wb_sel_o,
  output logic              wb_we_o,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic [2:0]        wb_cti_o,
  output logic [1:0]        wb_bte_o,
  input  logic              wb_ack_i,
  input  logic              wb_err_i,
  input  logic [DW-1:0]     wb_dat_i
);

  state_t            state_q, state_d;
  logic [AW-1:0]     adr_q, adr_d;
  logic [DW-1:0]     dat_q, dat_d;
  logic [DW/8-1:0]   sel_q, sel_d;
  logic              we_q, we_d;
  logic              cyc_q, cyc_d;
  logic              pready_q, pready_d;
  logic              pslverr_q, pslverr_d;
  logic [DW-1:0]     prdata_q, prdata_d;
  logic              dropped_q, dropped_d;

  logic              setup;
  logic              addr_ok;
  logic              expired;
  logic              fault;

  assign setup   = apb4_psel_i & ~apb4_penable_i;
  assign addr_ok = ADDR_OK(64'(apb4_paddr_i), AW);

`ifdef PERIPHERAL_BRIDGE_APB4_TIMEOUT_EN
  logic to_clr;
  logic to_en;

  assign to_clr = (state_q == IDLE) & setup & addr_ok;
  assign to_en  = (state_q == BUS);

  peripheral_bridge_apb4_timeout #(
    .LIMIT (TIMEOUT)
  ) u_timeout (
    .clk     (apb4_clk_i),
    .rst_n   (apb4_rst_i),
    .clr     (to_clr),
    .en      (to_en),
    .expired (expired)
  );
`else
  assign expired = 1'b0;
`endif

  // State and registered bus/APB outputs
  always_ff @(posedge apb4_clk_i) begin
    if (!apb4_rst_i) begin
      state_q   <= IDLE;
      adr_q     <= '0;
      dat_q     <= '0;
      sel_q     <= '0;
      we_q      <= 1'b0;
      cyc_q     <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      sel_q     <= sel_d;
      we_q      <= we_d;
      cyc_q     <= cyc_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
      dropped_q <= dropped_d;
    end
  end

  // Next state and next values of every registered output
  always_comb begin
    state_d   = state_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    sel_d     = sel_q;
    we_d      = we_q;
    cyc_d     = cyc_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    prdata_d  = prdata_q;
    dropped_d = dropped_q;
    fault     = 1'b0;

    case (state_q)
      IDLE: begin
        dropped_d = 1'b0;
        if (setup) begin
          if (addr_ok) begin
            adr_d   = {apb4_paddr_i[AW-1:2], 2'b00};
            we_d    = apb4_pwrite_i;
            dat_d   = apb4_pwrite_i ? apb4_pwdata_i : '0;
            sel_d   = apb4_pwrite_i ? apb4_pstrb_i : '1;
            cyc_d   = 1'b1;
            state_d = BUS;
          end else begin
            pready_d  = 1'b1;
            pslverr_d = 1'b1;
            prdata_d  = '0;
            state_d   = RESP;
          end
        end
      end

      BUS: begin
        if (!apb4_psel_i) begin
          dropped_d = 1'b1;
        end
        if (wb_err_i || wb_ack_i || expired) begin
          // err beats ack; a bare expiry (no ack) is also a fault
          fault = wb_err_i | ~wb_ack_i;
          cyc_d = 1'b0;
          // A master that abandoned the transfer gets no response
          if (dropped_q || !apb4_psel_i) begin
            state_d = IDLE;
          end else begin
            pready_d  = 1'b1;
            pslverr_d = fault;
            prdata_d  = (fault || we_q) ? '0 : wb_dat_i;
            state_d   = RESP;
          end
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        cyc_d   = 1'b0;
      end
    endcase
  end

  assign apb4_pready_o  = pready_q;
  assign apb4_pslverr_o = pslverr_q;
  assign apb4_prdata_o  = prdata_q;
  assign wb_adr_o       = adr_q;
  assign wb_dat_o       = dat_q;
  assign wb_sel_o       = sel_q;
  assign wb_we_o        = we_q;
  assign wb_cyc_o       = cyc_q;
  assign wb_stb_o       = cyc_q;
  assign wb_cti_o       = CLASSIC;
  assign wb_bte_o       = LINEAR;

endmodule

// File: tb/tb_peripheral_bridge_apb4.sv
// Self-checking bench for peripheral_bridge_apb4 with a Wishbone RAM stub.
module tb_peripheral_bridge_apb4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] paddr = '0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0] pwdata = '0;
  logic [3:0]  pstrb = '0;
  logic        pready, pslverr;
  logic [31:0] prdata;
  logic [7:0]  wb_adr;
  logic [31:0] wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel;
  logic        wb_we, wb_cyc, wb_stb, wb_ack, wb_err;
  logic [2:0]  wb_cti;
  logic [1:0]  wb_bte;

  int n_checks = 0;
  int n_fail   = 0;

  // 0 = normal RAM, 1 = error on first BUS cycle, 2 = never responds
  int slave_mode = 0;

  logic [31:0] slave_mem [64] = '{default: '0};
  logic [31:0] model_mem [64] = '{default: '0};

  always #5 clk = ~clk;

  peripheral_bridge_apb4 #(
    .PAW     (32),
    .AW      (8),
    .DW      (32),
    .TIMEOUT (15)
  ) dut (
    .apb4_clk_i     (clk),
    .apb4_rst_i     (rst),
    .apb4_paddr_i   (paddr),
    .apb4_psel_i    (psel),
    .apb4_penable_i (penable),
    .apb4_pwrite_i  (pwrite),
    .apb4_pwdata_i  (pwdata),
    .apb4_pstrb_i   (pstrb),
    .apb4_pready_o  (pready),
    .apb4_prdata_o  (prdata),
    .apb4_pslverr_o (pslverr),
    .wb_adr_o       (wb_adr),
    .wb_dat_o       (wb_dat_o),
    .wb_sel_o       (wb_sel),
    .wb_we_o        (wb_we),
    .wb_cyc_o       (wb_cyc),
    .wb_stb_o       (wb_stb),
    .wb_cti_o       (wb_cti),
    .wb_bte_o       (wb_bte),
    .wb_ack_i       (wb_ack),
    .wb_err_i       (wb_err),
    .wb_dat_i       (wb_dat_i)
  );

  // Classic-cycle RAM stub: ack toggles, one cycle after stb
  always @(posedge clk) begin
    if (!rst) begin
      wb_ack <= 1'b0;
    end else begin
      wb_ack <= wb_cyc & wb_stb & ~wb_ack & (slave_mode == 0);
      if (wb_cyc && wb_stb && !wb_ack && slave_mode == 0) begin
        if (wb_we) begin
          for (int b = 0; b < 4; b++)
            if (wb_sel[b]) slave_mem[wb_adr[7:2]][8*b +: 8] <= wb_dat_o[8*b +: 8];
        end
        wb_dat_i <= slave_mem[wb_adr[7:2]];
      end
    end
  end

  assign wb_err = wb_cyc & wb_stb & (slave_mode == 1);

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One APB transfer; reports whether pready came within budget cycles and when
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, input int budget,
                      output logic got, output int lat, output logic [31:0] rdata,
                      output logic err);
    logic in_range;
    in_range = (addr < 32'h100);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata; pstrb = strb;
    @(posedge clk); #1;
    penable = 1'b1;
    if (in_range) begin
      check("bus_cyc", 32'(wb_cyc), 32'd1);
      check("bus_stb", 32'(wb_stb), 32'd1);
      check("bus_adr", 32'(wb_adr), {24'd0, addr[7:2], 2'b00});
      check("bus_we", 32'(wb_we), 32'(wr));
      check("bus_sel", 32'(wb_sel), wr ? 32'(strb) : 32'hF);
      if (wr) check("bus_dat", wb_dat_o, wdata);
    end else begin
      check("oor_no_cyc", 32'(wb_cyc), 32'd0);
    end
    got = 1'b0; lat = 0; rdata = '0; err = 1'b0;
    for (int n = 1; n <= budget; n++) begin
      if (pready) begin
        got = 1'b1; lat = n; rdata = prdata; err = pslverr;
        break;
      end
      @(posedge clk); #1;
    end
    if (got) begin
      @(posedge clk); #1;
      check("pready_one_cycle", 32'(pready), 32'd0);
      check("cyc_after_resp", 32'(wb_cyc), 32'd0);
    end
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  // Transfer against the normal RAM stub, checked against the memory model
  task automatic run(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] strb, output logic [31:0] rdata);
    logic got, err, oor;
    int lat;
    logic [31:0] exp_rd;
    logic [5:0] w;
    oor = (addr >= 32'h100);
    w = addr[7:2];
    exp_rd = (wr || oor) ? 32'd0 : model_mem[w];
    xfer(wr, addr, wdata, strb, 20, got, lat, rdata, err);
    check("ready_seen", 32'(got), 32'd1);
    check("latency", 32'(lat), oor ? 32'd1 : 32'd3);
    check("pslverr", 32'(err), 32'(oor));
    check("prdata", rdata, exp_rd);
    if (wr && !oor)
      for (int b = 0; b < 4; b++)
        if (strb[b]) model_mem[w][8*b +: 8] = wdata[8*b +: 8];
  endtask

  logic [31:0] rd;
  logic        got, err, seen;
  int          lat;
  logic        wr_r;
  logic [31:0] addr_r;

  initial begin
    // Reset state
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pready", 32'(pready), 32'd0);
    check("rst_pslverr", 32'(pslverr), 32'd0);
    check("rst_prdata", prdata, 32'd0);
    check("rst_cyc", 32'(wb_cyc), 32'd0);
    check("rst_stb", 32'(wb_stb), 32'd0);
    check("rst_we", 32'(wb_we), 32'd0);
    check("rst_sel", 32'(wb_sel), 32'd0);
    check("rst_adr", 32'(wb_adr), 32'd0);
    check("rst_dat", wb_dat_o, 32'd0);
    check("cti", 32'(wb_cti), 32'd0);
    check("bte", 32'(wb_bte), 32'd0);
    rst = 1'b1;

    // Basic write/read
    run(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd);
    run(1'b0, 32'h10, 32'h0, 4'h0, rd);
    check("read_10", rd, 32'hDEADBEEF);

    // Byte strobes
    run(1'b1, 32'h20, 32'h11223344, 4'hF, rd);
    run(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, rd);
    run(1'b0, 32'h20, 32'h0, 4'h0, rd);
    check("read_20_merge", rd, 32'h11BB33DD);

    // Zero strobes still complete; nothing changes
    run(1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, rd);
    run(1'b0, 32'h20, 32'h0, 4'h0, rd);
    check("read_20_nostrb", rd, 32'h11BB33DD);

    // Window edges
    run(1'b1, 32'hFF, 32'h5A5A5A5A, 4'hF, rd);
    run(1'b0, 32'hFC, 32'h0, 4'h0, rd);
    run(1'b0, 32'h100, 32'h0, 4'h0, rd);
    run(1'b1, 32'h100, 32'h12345678, 4'hF, rd);

    // Slave error on first BUS cycle, then recovery
    slave_mode = 1;
    xfer(1'b0, 32'h10, 32'h0, 4'h0, 20, got, lat, rd, err);
    check("err_ready", 32'(got), 32'd1);
    check("err_latency", 32'(lat), 32'd2);
    check("err_pslverr", 32'(err), 32'd1);
    check("err_prdata", rd, 32'd0);
    slave_mode = 0;
    run(1'b0, 32'h10, 32'h0, 4'h0, rd);

    // Randomised traffic
    for (int i = 0; i < 30; i++) begin
      wr_r = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) addr_r = 32'h100 + $urandom_range(0, 32'hFFFF);
      else addr_r = $urandom_range(0, 255);
      run(wr_r, addr_r, $urandom, 4'($urandom_range(0, 15)), rd);
    end

    // Master abandons the transfer while in BUS
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h30; pwdata = 32'hCAFEF00D; pstrb = 4'hF;
    @(posedge clk); #1;
    psel = 1'b0; pwrite = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 6; n++) begin
      if (pready) seen = 1'b1;
      @(posedge clk); #1;
    end
    check("drop_no_pready", 32'(seen), 32'd0);
    check("drop_cyc_low", 32'(wb_cyc), 32'd0);
    model_mem[12] = 32'hCAFEF00D;
    run(1'b0, 32'h30, 32'h0, 4'h0, rd);

    // Slave that never answers
    slave_mode = 2;
`ifdef PERIPHERAL_BRIDGE_APB4_TIMEOUT_EN
    xfer(1'b0, 32'h10, 32'h0, 4'h0, 30, got, lat, rd, err);
    check("to_ready", 32'(got), 32'd1);
    check("to_latency", 32'(lat), 32'd16);
    check("to_pslverr", 32'(err), 32'd1);
    check("to_prdata", rd, 32'd0);
`else
    xfer(1'b0, 32'h10, 32'h0, 4'h0, 30, got, lat, rd, err);
    check("hang_no_ready", 32'(got), 32'd0);
    check("hang_cyc_held", 32'(wb_cyc), 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
`endif

    // Reset in the middle of a BUS cycle
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h10;
    @(posedge clk); #1;
    penable = 1'b1;
    check("midrst_cyc_before", 32'(wb_cyc), 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;
    check("midrst_cyc", 32'(wb_cyc), 32'd0);
    check("midrst_stb", 32'(wb_stb), 32'd0);
    check("midrst_pready", 32'(pready), 32'd0);
    check("midrst_sel", 32'(wb_sel), 32'd0);
    check("midrst_adr", 32'(wb_adr), 32'd0);
    rst = 1'b1; psel = 1'b0; penable = 1'b0;
    slave_mode = 0;
    @(posedge clk); #1;
    check("midrst_no_pready", 32'(pready), 32'd0);
    run(1'b0, 32'h10, 32'h0, 4'h0, rd);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/peripheral_bridge_apb4.md
# peripheral_bridge_apb4

APB4 slave front-end that converts APB4 transfers into single classic cycles on the Wishbone-style `apb4_*` slave port of the single-port RAM. It sits directly upstream of `peripheral_spram_apb4`, drives its address, data, strobe and cycle controls, and returns its acknowledge or error and read data as `pready`, `pslverr` and `prdata`. It issues one bus cycle per APB transfer, range-checks addresses, and can optionally abort stalled cycles.

## Interface
- `PAW`, 32, APB address width.
- `AW`, 8, RAM byte-address width; legal window is 0 .. 2^AW-1.
- `DW`, 32, data width; fixed at 32, with 4 byte strobes.
- `TIMEOUT`, 15, maximum cycles spent in BUS before abort; used only with the timeout macro.

Ports:
- `apb4_clk_i`  in  1  clock; everything is rising-edge.
- `apb4_rst_i`  in  1  reset, **synchronous, active-low**.
- `apb4_paddr_i`  in  PAW  APB address.
- `apb4_psel_i`, `apb4_penable_i`, `apb4_pwrite_i`  in  1  APB controls.
- `apb4_pwdata_i`  in  DW  write data.
- `apb4_pstrb_i`  in  4  write byte strobes.
- `apb4_pready_o`  out  1  transfer complete.
- `apb4_prdata_o`  out  DW  read data.
- `apb4_pslverr_o`  out  1  transfer error.
- `wb_adr_o`  out  AW  word-aligned byte address; bits [1:0] are always 0.
- `wb_dat_o`  out  DW  write data.
- `wb_sel_o`  out  4  byte selects.
- `wb_we_o`, `wb_cyc_o`, `wb_stb_o`  out  1  cycle controls.
- `wb_cti_o`  out  3  constant 3'b000.
- `wb_bte_o`  out  2  constant 2'b00.
- `wb_ack_i`, `wb_err_i`  in  1  slave response.
- `wb_dat_i`  in  DW  read data.

## Operation
- FSM states: IDLE, BUS, RESP.
- **IDLE**
  - A setup phase (`psel & !penable`) latches address, write flag, write data and selects, then moves to BUS.
  - If `paddr >= 2^AW`, it instead moves to RESP with error set and no bus cycle issued.
- **BUS**
  - `wb_cyc_o` and `wb_stb_o` are high. All `wb_*` outputs are registered and held stable until the response.
  - `wb_ack_i` latches `wb_dat_i` on reads (write data is 0), then moves to RESP.
  - `wb_err_i` moves to RESP with error set. Error wins over ack in the same cycle.
- **RESP**
  - `pready` is high for exactly one cycle, with `pslverr` and `prdata` valid. `cyc` and `stb` are low.
  - Next state is IDLE.
- Selects: `wb_sel_o = pstrb` on writes and `4'hF` on reads.
  - A write with `pstrb = 0` still runs a cycle and completes normally, with no bytes written.
- `prdata` is 0 on writes and on errors.
- Errored transfers are not retried.
- If `psel` drops while in BUS (a protocol violation), the bus cycle still completes, the response is discarded, and the FSM returns to IDLE.

## Timing
- Reset values: `pready` 0, `pslverr` 0, `prdata` 0, `cyc`/`stb`/`we` 0, `sel` 0, `adr` 0, `dat` 0. State is IDLE.
- Nominal transfer against the RAM:
  - Cycle 0: setup phase.
  - Cycle 1: `cyc`/`stb` high.
  - Cycle 2: RAM `ack` high; the write commits in this cycle.
  - Cycle 3: `pready` high.
  - The transfer therefore has 2 APB wait states.
- `cyc` and `stb` drop on the edge after ack is sampled. This is required because the RAM toggles ack on classic cycles.
- An out-of-range transfer reaches `pready` in cycle 1 with `pslverr` = 1.
- Back-to-back transfers: the next setup phase can occur the cycle after RESP.
- Reset asserted mid-transfer: all outputs take reset values on the next edge. No partial `pready` is produced.

## Configuration
- `PERIPHERAL_BRIDGE_APB4_TIMEOUT_EN` defined:
  - A counter clears on entry to BUS and increments each BUS cycle.
  - When it reaches `TIMEOUT` without ack or error, `cyc`/`stb` drop and the FSM moves to RESP with `pslverr` = 1.
  - Ack in the same cycle as the limit wins, giving a normal completion.
- Macro undefined: no counter is present, and BUS waits indefinitely.

## Structure
- `peripheral_bridge_apb4_pkg` holds:
  - the state enum;
  - CTI/BTE constants (CLASSIC, END_OF_BURST, LINEAR);
  - `ADDR_OK` range-check function.
- Optional sub-module `peripheral_bridge_apb4_timeout`: a counter with `clr`, `en` and `expired` signals. It is instantiated only under the macro.

## Test plan
- Write `paddr` 0x10, data 0xDEADBEEF, `pstrb` 4'hF, then read 0x10. Read returns 0xDEADBEEF, `pslverr` = 0, and `pready` appears 3 cycles after setup.
- Write 0x11223344 to 0x20, then write 0xAABBCCDD with `pstrb` 4'b0101, then read 0x20. Read returns 0x11BB33DD.
- Read `paddr` 0x100 with AW = 8. `pready` comes 1 cycle after setup, `pslverr` = 1, `prdata` = 0, and `cyc` never rises.
- Stub slave asserts `wb_err_i` on the first BUS cycle. `pslverr` = 1, `prdata` = 0, and the next transfer succeeds.
- With the macro defined and the slave never acking, `pslverr` = 1 after `TIMEOUT` = 15 BUS cycles. Without the macro, `pready` stays 0.
- Drive reset low while in BUS. The next edge gives `cyc` = 0 and `pready` = 0; after release, a read of 0x10 returns the previously written value.
